// File: rtl/csr_if.sv
// csr_if: bundles the CSR access bus, trap/mret strobes and interrupt
// signals exchanged between the pipeline controller and the CSR file.
interface csr_if;
   logic [11:0] raddr;
   logic [31:0] rdata;
   logic        ctrl_addr_valid;
   logic        wen;
   logic [1:0]  wop;
   logic [11:0] waddr;
   logic [31:0] wsrc;
   logic        ctrl_trap;
   logic        ctrl_mret;
   logic [31:0] trap_pc;
   logic [4:0]  trap_cause;
   logic [31:0] trap_tval;
   logic        instr_retired;
   logic        irq_soft;
   logic        irq_timer;
   logic        irq_ext;
   logic        irq_pending;
   logic [4:0]  irq_cause;
   logic [31:0] trap_vector;
   logic [31:0] epc_out;
   logic        ctrl_mie;

   // Pipeline-controller side
   modport master (
      output raddr, wen, wop, waddr, wsrc, ctrl_trap, ctrl_mret, trap_pc,
             trap_cause, trap_tval, instr_retired, irq_soft, irq_timer, irq_ext,
      input  rdata, ctrl_addr_valid, irq_pending, irq_cause, trap_vector,
             epc_out, ctrl_mie
   );

   // CSR-file side
   modport slave (
      input  raddr, wen, wop, waddr, wsrc, ctrl_trap, ctrl_mret, trap_pc,
             trap_cause, trap_tval, instr_retired, irq_soft, irq_timer, irq_ext,
      output rdata, ctrl_addr_valid, irq_pending, irq_cause, trap_vector,
             epc_out, ctrl_mie
   );
endinterface

// File: rtl/csr_unit.sv
// csr_unit: RV32 machine-mode CSR file with read-modify-write ops, wide
// cycle/instret counters, hardware-reflected mip and interrupt/trap vectoring.
module csr_unit #(
   parameter logic [31:0] HART_ID     = 32'h0000_0000,
   parameter int          CNT_WIDTH   = 64,
   parameter bit          VECTORED    = 1'b1,
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
   input logic  ctrl_clk,
   input logic  ctrl_reset,
   csr_if.slave bus
);

   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MISA     = 12'h301;
   localparam logic [11:0] A_MIE      = 12'h304;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MCNTINH  = 12'h320;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MTVAL    = 12'h343;
   localparam logic [11:0] A_MIP      = 12'h344;
   localparam logic [11:0] A_MCYCLE   = 12'hB00;
   localparam logic [11:0] A_MINSTRET = 12'hB02;
   localparam logic [11:0] A_MCYCLEH  = 12'hB80;
   localparam logic [11:0] A_MINSTRH  = 12'hB82;
   localparam logic [11:0] A_MHARTID  = 12'hF14;

   localparam logic [31:0] MISA_VAL = 32'h4000_0100;
   localparam logic [31:0] MIE_MASK = 32'hFFFF_0888;
   // Implemented counter bits; the upper half mask limits high-half writes.
   localparam logic [63:0] CNT_MASK = (CNT_WIDTH >= 64) ? {64{1'b1}} :
                                      ((64'd1 << CNT_WIDTH) - 64'd1);
   localparam logic [31:0] HI_MASK  = CNT_MASK[63:32];

   logic                 mst_mie_q, mst_mie_d;
   logic                 mst_mpie_q, mst_mpie_d;
   logic [31:0]          mie_q, mie_d;
   logic [31:0]          mtvec_q, mtvec_d;
   logic [31:0]          mscratch_q, mscratch_d;
   logic [31:0]          mepc_q, mepc_d;
   logic [31:0]          mcause_q, mcause_d;
   logic [31:0]          mtval_q, mtval_d;
   logic [2:0]           mip_q, mip_d;          // {MEIP, MTIP, MSIP}
   logic [1:0]           inhibit_q, inhibit_d;  // {IR, CY}
   logic [CNT_WIDTH-1:0] mcycle_q, mcycle_d;
   logic [CNT_WIDTH-1:0] minstret_q, minstret_d;
   logic                 irq_pending_q, irq_pending_d;

   logic [63:0] mcycle_x, minstret_x;
   logic [31:0] rd_val, wr_old, wr_new, wr_val, tvec;
   logic        wr_ok, wr_fire;
   logic [2:0]  irq_act;
   logic [4:0]  irq_cause_c;

   assign mcycle_x   = 64'(mcycle_q);
   assign minstret_x = 64'(minstret_q);

   function automatic logic csr_valid(input logic [11:0] a);
      case (a)
         A_MSTATUS, A_MISA, A_MIE, A_MTVEC, A_MCNTINH, A_MSCRATCH, A_MEPC,
         A_MCAUSE, A_MTVAL, A_MIP, A_MCYCLE, A_MINSTRET, A_MCYCLEH,
         A_MINSTRH, A_MHARTID: return 1'b1;
         default:              return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] csr_read(input logic [11:0] a);
      logic [31:0] v;
      v = '0;
      case (a)
         A_MSTATUS:  v = {19'b0, 2'b11, 3'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
         A_MISA:     v = MISA_VAL;
         A_MIE:      v = mie_q;
         A_MTVEC:    v = mtvec_q;
         A_MCNTINH:  v = {29'b0, inhibit_q[1], 1'b0, inhibit_q[0]};
         A_MSCRATCH: v = mscratch_q;
         A_MEPC:     v = mepc_q;
         A_MCAUSE:   v = mcause_q;
         A_MTVAL:    v = mtval_q;
         A_MIP:      v = {20'b0, mip_q[2], 3'b0, mip_q[1], 3'b0, mip_q[0], 3'b0};
         A_MCYCLE:   v = mcycle_x[31:0];
         A_MCYCLEH:  v = mcycle_x[63:32];
         A_MINSTRET: v = minstret_x[31:0];
         A_MINSTRH:  v = minstret_x[63:32];
         A_MHARTID:  v = HART_ID;
         default:    v = '0;
      endcase
      return v;
   endfunction

   function automatic logic cause_legal(input logic [31:0] c);
      if (c[30:4] != '0) return 1'b0;
      if (c[31]) return (c[3:0] == 4'd3) || (c[3:0] == 4'd7) || (c[3:0] == 4'd11);
      return (c[3:0] != 4'd10) && (c[3:0] != 4'd14);
   endfunction

   // Returns {writable, value to store}; WARL rejects fall back to the old value.
   function automatic logic [32:0] legalize(input logic [11:0] a,
                                            input logic [31:0] nv,
                                            input logic [31:0] ov);
      case (a)
         A_MSTATUS:  return {1'b1, (nv & 32'h0000_0088) | 32'h0000_1800};
         A_MIE:      return {1'b1, nv & MIE_MASK};
         A_MTVEC:    return {1'b1, ((nv[1:0] == 2'b00) ||
                                    ((nv[1:0] == 2'b01) && (VECTORED == 1'b1))) ? nv : ov};
         A_MCNTINH:  return {1'b1, nv & 32'h0000_0005};
         A_MSCRATCH: return {1'b1, nv};
         A_MEPC:     return {1'b1, nv & ~32'h3};
         A_MCAUSE:   return {1'b1, cause_legal(nv) ? nv : ov};
         A_MTVAL:    return {1'b1, nv};
         A_MCYCLE,
         A_MINSTRET: return {1'b1, nv};
         A_MCYCLEH,
         A_MINSTRH:  return {1'b1, nv & HI_MASK};
         default:    return {1'b0, ov};
      endcase
   endfunction

   // Evaluate the RMW write operand, apply legality masking, and bypass reads
   always_comb begin
      wr_old = csr_read(bus.waddr);
      case (bus.wop)
         2'b01:   wr_new = bus.wsrc;
         2'b10:   wr_new = wr_old | bus.wsrc;
         2'b11:   wr_new = wr_old & ~bus.wsrc;
         default: wr_new = wr_old;
      endcase
      {wr_ok, wr_val} = legalize(bus.waddr, wr_new, wr_old);
      // Trap and mret take the edge; a write presented alongside them is lost.
      wr_fire = bus.wen && (bus.wop != 2'b00) && wr_ok && !bus.ctrl_trap && !bus.ctrl_mret;
      rd_val  = csr_read(bus.raddr);
      if (wr_fire && (bus.raddr == bus.waddr)) rd_val = wr_val;
   end

   // Next-state for all CSR state: counters, mip sampling, trap > mret > write
   always_comb begin
      mst_mie_d     = mst_mie_q;
      mst_mpie_d    = mst_mpie_q;
      mie_d         = mie_q;
      mtvec_d       = mtvec_q;
      mscratch_d    = mscratch_q;
      mepc_d        = mepc_q;
      mcause_d      = mcause_q;
      mtval_d       = mtval_q;
      inhibit_d     = inhibit_q;
      mcycle_d      = mcycle_q;
      minstret_d    = minstret_q;
      mip_d         = {bus.irq_ext, bus.irq_timer, bus.irq_soft};
      irq_pending_d = mst_mie_q && ((mip_q & {mie_q[11], mie_q[7], mie_q[3]}) != 3'b000);

      if (!inhibit_q[0]) mcycle_d = mcycle_q + CNT_WIDTH'(1);
      if (bus.instr_retired && !inhibit_q[1]) minstret_d = minstret_q + CNT_WIDTH'(1);

      if (bus.ctrl_trap) begin
         mepc_d     = bus.trap_pc & ~32'h3;
         mcause_d   = {bus.trap_cause[4], 27'b0, bus.trap_cause[3:0]};
         mtval_d    = bus.trap_tval;
         mst_mpie_d = mst_mie_q;
         mst_mie_d  = 1'b0;
      end else if (bus.ctrl_mret) begin
         mst_mie_d  = mst_mpie_q;
         mst_mpie_d = 1'b1;
      end else if (wr_fire) begin
         case (bus.waddr)
            A_MSTATUS: begin
               mst_mie_d  = wr_val[3];
               mst_mpie_d = wr_val[7];
            end
            A_MIE:      mie_d      = wr_val;
            A_MTVEC:    mtvec_d    = wr_val;
            A_MCNTINH:  inhibit_d  = {wr_val[2], wr_val[0]};
            A_MSCRATCH: mscratch_d = wr_val;
            A_MEPC:     mepc_d     = wr_val;
            A_MCAUSE:   mcause_d   = wr_val;
            A_MTVAL:    mtval_d    = wr_val;
            A_MCYCLE:   mcycle_d   = CNT_WIDTH'({mcycle_x[63:32], wr_val});
            A_MCYCLEH:  mcycle_d   = CNT_WIDTH'({wr_val, mcycle_x[31:0]});
            A_MINSTRET: minstret_d = CNT_WIDTH'({minstret_x[63:32], wr_val});
            A_MINSTRH:  minstret_d = CNT_WIDTH'({wr_val, minstret_x[31:0]});
            default: ;
         endcase
      end
   end

   // Highest-priority enabled pending interrupt: external > software > timer
   always_comb begin
      irq_act = mip_q & {mie_q[11], mie_q[7], mie_q[3]};
      if (irq_act[2])      irq_cause_c = 5'b1_1011;
      else if (irq_act[0]) irq_cause_c = 5'b1_0011;
      else if (irq_act[1]) irq_cause_c = 5'b1_0111;
      else                 irq_cause_c = 5'b0_0000;
   end

   // Handler address: base, offset by 4*code only for vectored interrupts
   always_comb begin
      tvec = {mtvec_q[31:2], 2'b00};
      if ((mtvec_q[1:0] == 2'b01) && bus.trap_cause[4])
         tvec = tvec + {26'b0, bus.trap_cause[3:0], 2'b00};
   end

   // State registers with asynchronous reset
   always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         mst_mie_q     <= 1'b0;
         mst_mpie_q    <= 1'b0;
         mie_q         <= '0;
         mtvec_q       <= RESET_MTVEC;
         mscratch_q    <= '0;
         mepc_q        <= '0;
         mcause_q      <= '0;
         mtval_q       <= '0;
         mip_q         <= '0;
         inhibit_q     <= '0;
         mcycle_q      <= '0;
         minstret_q    <= '0;
         irq_pending_q <= 1'b0;
      end else begin
         mst_mie_q     <= mst_mie_d;
         mst_mpie_q    <= mst_mpie_d;
         mie_q         <= mie_d;
         mtvec_q       <= mtvec_d;
         mscratch_q    <= mscratch_d;
         mepc_q        <= mepc_d;
         mcause_q      <= mcause_d;
         mtval_q       <= mtval_d;
         mip_q         <= mip_d;
         inhibit_q     <= inhibit_d;
         mcycle_q      <= mcycle_d;
         minstret_q    <= minstret_d;
         irq_pending_q <= irq_pending_d;
      end
   end

   assign bus.rdata           = rd_val;
   assign bus.ctrl_addr_valid = csr_valid(bus.raddr);
   assign bus.irq_pending     = irq_pending_q;
   assign bus.irq_cause       = irq_cause_c;
   assign bus.trap_vector     = tvec;
   assign bus.epc_out         = mepc_q;
   assign bus.ctrl_mie        = mst_mie_q;

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Parametrised next-generation machine-mode CSR file for the RV32 core.
- Adds internal CSR read-modify-write ops, 64-bit-capable mcycle/minstret counters with mcountinhibit, and hardware-reflected interrupt pending bits.
- Adds prioritised interrupt request generation and a computed trap-vector output (direct or vectored mode).
- Sits beside the decode/execute stage; the pipeline controller drives the trap and mret strobes.

Parameters:
HART_ID, 0, value returned by mhartid (0xF14)
CNT_WIDTH, 64, implemented width of mcycle/minstret, legal range 32..64; unimplemented bits read 0
VECTORED, 1, 1 allows mtvec.MODE=1 (vectored); 0 means only direct mode is legal
RESET_MTVEC, 32'h0000_0000, reset value of mtvec (MODE bits must be 0)

Ports:
ctrl_clk  in  1  clock
ctrl_reset  in  1  asynchronous active-high reset
raddr  in  12  CSR read address
rdata  out  32  read data, combinational, with same-cycle write bypass
ctrl_addr_valid  out  1  raddr names an implemented CSR
wen  in  1  CSR write strobe
wop  in  2  01 RW, 10 RS (set), 11 RC (clear), 00 no write
waddr  in  12  CSR write address
wsrc  in  32  write operand
ctrl_trap  in  1  take trap this cycle
ctrl_mret  in  1  execute mret this cycle
trap_pc  in  32  pc saved to mepc on trap
trap_cause  in  5  {interrupt, code[3:0]}
trap_tval  in  32  value saved to mtval on trap
instr_retired  in  1  one instruction retired this cycle
irq_soft, irq_timer, irq_ext  in  1 each  level interrupt inputs
irq_pending  out  1  enabled interrupt pending, registered
irq_cause  out  5  {1, code} of highest-priority pending interrupt
trap_vector  out  32  handler target for the current trap_cause
epc_out  out  32  current mepc
ctrl_mie  out  1  mstatus.MIE

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: only MIE[3] and MPIE[7] are writable; MPP[12:11] is hardwired to 11.
  - misa 0x301: read-only, 0x4000_0100.
  - mie 0x304: writable bits 3, 7, 11 and 31:16.
  - mtvec 0x305, mscratch 0x340.
  - mepc 0x341: bits 1:0 are forced to 0.
  - mcause 0x342, mtval 0x343.
  - mip 0x344: fully read-only.
  - mcountinhibit 0x320: only bits 0 and 2 are writable.
  - mcycle 0xB00 / mcycleh 0xB80, minstret 0xB02 / minstreth 0xB82.
  - mhartid 0xF14.
- Unimplemented raddr: rdata=0 and ctrl_addr_valid=0.
- Writes to unimplemented or read-only CSRs are silently dropped.
- Write value: new = wsrc (RW), old|wsrc (RS), or old&~wsrc (RC), where old is the pre-write register value. Legality masking is applied after the op.
- mtvec WARL:
  - Accept the write only if MODE (new[1:0]) is 0, or is 1 with VECTORED=1.
  - Otherwise keep the old value.
- mcause WARL: accept only legal causes; otherwise keep the old value.
  - Interrupt causes: codes 3, 7, 11.
  - Exception causes: codes 0..15 except 10 and 14.
- Bypass: when wen=1, wop!=0 and raddr==waddr, rdata returns the post-mask value that will be written at the next edge.
- Update priority per edge: ctrl_trap > ctrl_mret > CSR write. A write presented with trap or mret is dropped.
- Trap: mepc<=trap_pc&~3, mcause<={trap_cause[4],27'b0,trap_cause[3:0]}, mtval<=trap_tval, MPIE<=MIE, MIE<=0.
- mret: MIE<=MPIE, MPIE<=1.
- Counters:
  - mcycle increments every cycle unless mcountinhibit[0]=1.
  - minstret increments when instr_retired=1 unless mcountinhibit[2]=1.
  - Both wrap to 0 modulo 2^CNT_WIDTH.
  - Writing a low or high half replaces only that half, and suppresses that counter's increment in that cycle.
  - With CNT_WIDTH<64, high-half bits above CNT_WIDTH-32 read 0 and writes to them are dropped.
  - Counters continue counting through trap and mret.
- mip:
  - MSIP[3], MTIP[7] and MEIP[11] are sampled from irq_soft, irq_timer and irq_ext every edge, so mip lags the inputs by one cycle.
  - All other mip bits are 0.
- Interrupt request:
  - irq_pending is registered: irq_pending <= MIE & |(mip & mie & 0x888).
  - irq_cause is combinational from the current mip&mie, with priority ext(11) > soft(3) > timer(7).
  - irq_cause is 5'b0 when nothing is pending.
- trap_vector (combinational) = {mtvec[31:2],2'b00}, plus 4*trap_cause[3:0] when mtvec[1:0]==1 and trap_cause[4]==1.
- Reset (asynchronous; reset has priority over every other event):
  - mstatus=0x0000_1800, mie=mip=0, mtvec=RESET_MTVEC.
  - mscratch=mepc=mcause=mtval=0, mcountinhibit=0, counters=0.
  - irq_pending=0, ctrl_mie=0, epc_out=0.
- Reset asserted mid-operation discards any in-flight write, trap or mret.

Test Plan:
1. RS then RC on mie: write RS 0x888 -> read 0x888; write RC 0x080 -> read 0x808; same-cycle bypass of the RC write reads 0x808.
2. Counter rollover, CNT_WIDTH=40:
   - Write mcyclelo 0xFFFF_FFFF and mcycleh 0xFF in consecutive cycles.
   - Next cycle the count equals 0xFF_FFFF_FFFF; one cycle after that, mcycle=mcycleh=0.
   - Write mcycleh 0xFFFF_FFFF -> reads 0xFF.
3. Inhibit: with mcountinhibit=0x4 and instr_retired=1 for 10 cycles, minstret is unchanged while mcycle advances by 10.
4. Interrupt priority:
   - Setup: mie=0x888, MIE=1, irq_timer=irq_ext=1.
   - One cycle later irq_cause=5'b1_1011, and irq_pending is 1 on the next edge.
   - Drop irq_ext -> irq_cause=5'b1_0111.
   - MIE=0 -> irq_pending=0.
5. Vectored trap:
   - Setup: mtvec=0x8000_0101, VECTORED=1, trap_cause=5'b1_0111.
   - Then trap_vector=0x8000_011C.
   - ctrl_trap with trap_pc=0x1236 -> mepc=0x1234, mcause=0x8000_0007, MIE=0, MPIE=previous MIE.
   - mret -> MIE restored, MPIE=1.
6. Simultaneous events and reset:
   - ctrl_trap, ctrl_mret and an mscratch write in the same cycle -> only the trap effects occur.
   - With VECTORED=0, writing mtvec 0x101 leaves the old mtvec.
   - Asserting ctrl_reset asynchronously mid-cycle immediately zeroes irq_pending and sets mstatus to 0x1800.
